jtpopeye_sdram_arb: RTL and testbench
=====================================

// Module: jtpopeye_sdram_arb
// PURPOSE
//  Shares the single SDRAM read port between main CPU ROM (32 kB, byte reads) and OBJ ROM (32-bit words).
//  One-word cache per requester, alternating grant on contention, idle-time refresh enable.
//  Download/loop-reset gating: holds requests off until ROM load completes, then raises ready for CPU reset release.
// PARAMETERS
//  MAIN_OFFSET   22'h00000  SDRAM word address of main ROM word 0
//  OBJ_OFFSET    22'h02000  SDRAM word address of OBJ ROM word 0
//  REFRESH_IDLE  8          consecutive idle cycles before refresh_en rises (1..255)
// PORTS
//  clk          in   1   system clock, single domain
//  rst_n        in   1   synchronous reset, active low
//  downloading  in   1   ROM download in progress
//  loop_rst     in   1   loader reset request
//  main_cs      in   1   main CPU ROM access
//  main_addr    in   15  main byte address
//  main_dout    out  8   main read byte
//  main_ok      out  1   main_dout valid for current main_addr
//  obj_cs       in   1   OBJ ROM access
//  obj_addr     in   13  OBJ word address
//  obj_dout     out  32  OBJ read word
//  obj_ok       out  1   obj_dout valid for current obj_addr
//  sdram_req    out  1   read request, held until sdram_ack
//  sdram_ack    in   1   request accepted
//  data_rdy     in   1   data_read valid (1-cycle pulse)
//  data_read    in   32  SDRAM read data
//  sdram_addr   out  22  SDRAM word address
//  refresh_en   out  1   SDRAM may refresh now
//  ready        out  1   ROMs loaded, arbiter operational
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, both cache valids 0, state IDLE, last_grant=OBJ (main wins first tie).
//  Gating: downloading|loop_rst high -> same as reset except last_grant kept; ready=0.
//   ready rises 1 cycle after both low with rst_n high.
//  Caches: main tag = main_addr[14:2] (13b), obj tag = obj_addr; each holds one 32-bit word + valid.
//  Hit/miss: main_hit = main_cs & main_valid & tag==main_addr[14:2]; main_miss = main_cs & ~main_hit. Same for obj.
//  main_ok/obj_ok registered: = hit of previous cycle. Hit -> ok 1 cycle later.
//  main_dout registered: byte main_addr[1:0] of cached word, byte0 = bits[7:0].
//  obj_dout registered: cached word.
//  FSM IDLE -> REQ -> WAIT -> IDLE:
//   IDLE: if any miss and ready, grant: single miss -> that requester; both -> the one != last_grant.
//    Capture grantee tag, drive sdram_addr = OFFSET + tag (22-bit add, no overflow check), sdram_req=1, go REQ.
//   REQ: hold sdram_req/sdram_addr stable until sdram_ack; then sdram_req=0, go WAIT.
//    data_rdy in the same cycle as sdram_ack is honoured as in WAIT.
//   WAIT: on data_rdy, write data_read + captured tag into grantee cache, valid=1, last_grant=grantee, go IDLE.
//  Miss latency: ok rises 2 cycles after data_rdy if address unchanged.
//  Address change mid-transfer: fill still stored under captured tag; ok stays low (tag mismatch) and a new miss is issued next IDLE.
//  cs dropped mid-transfer: transfer completes and fills cache; no abort.
//  Gating/reset mid-transfer: state -> IDLE, sdram_req=0 same edge; late data_rdy/sdram_ack ignored in IDLE.
//  refresh_en: saturating idle counter; counts while IDLE with no miss, clears otherwise.
//   refresh_en=1 when counter >= REFRESH_IDLE; drops the cycle a grant is issued.
//  Starvation: back-to-back contention alternates strictly main/obj.
// TESTING
//  Reset then downloading 1->0: ready=0 during load, ready=1 one cycle after; all ok=0, sdram_req=0.
//  main_cs, main_addr=15'h0005, SDRAM returns 32'hDDCCBBAA: sdram_addr=22'h000001; main_dout=8'hBB, main_ok 2 cycles after data_rdy; main_addr=15'h0006 -> 8'hCC 1 cycle later, no new req.
//  Simultaneous misses main 15'h0010, obj 13'h0003 from reset: main granted first (addr 22'h000004), then obj (22'h002003); both oks high after second fill.
//  obj_addr changes 13'h0003->13'h0004 while in WAIT: fill tagged 3, obj_ok stays 0, second req at 22'h002004.
//  No cs for REFRESH_IDLE=8 cycles: refresh_en=1 on 9th cycle; main miss -> refresh_en=0 same cycle sdram_req=1.
//  rst_n low during REQ: sdram_req=0 next edge; data_rdy pulse afterward leaves caches invalid.

Source files
------------

// File: rtl/jtpopeye_sdram_arb.sv
// jtpopeye_sdram_arb
//
// Shares one SDRAM read port between two ROM clients:
//   - main CPU ROM: 32 kB, byte-addressed reads
//   - OBJ ROM: 32-bit word reads
// Each client has a one-word cache. A miss raises a single SDRAM read. When
// both clients miss in the same cycle, the client that was not served last
// wins, so the two clients take turns.
//
// While a ROM download or a loader reset is in progress, the arbiter is held
// in its reset state, with caches flushed and outputs low. The one exception
// is the turn-taking history, which survives. Once the hold is released,
// 'ready' rises one cycle later and tells the rest of the system that the CPU
// may leave reset.
//
// Ports
//   clk          system clock (single domain)
//   rst_n        synchronous reset, active low
//   downloading  ROM download in progress (holds the arbiter idle)
//   loop_rst     loader reset request (holds the arbiter idle)
//   main_cs      main CPU ROM access strobe
//   main_addr    main CPU byte address (15 bits)
//   main_dout    byte read for main CPU (registered)
//   main_ok      main_dout is valid for the current main_addr
//   obj_cs       OBJ ROM access strobe
//   obj_addr     OBJ ROM word address (13 bits)
//   obj_dout     word read for OBJ (registered)
//   obj_ok       obj_dout is valid for the current obj_addr
//   sdram_req    read request, held until sdram_ack
//   sdram_ack    SDRAM controller accepted the request
//   data_rdy     one-cycle pulse, data_read is valid
//   data_read    SDRAM read data (32 bits)
//   sdram_addr   SDRAM word address of the request
//   refresh_en   SDRAM controller may refresh now
//   ready        ROMs loaded, arbiter operational
module jtpopeye_sdram_arb #(
  parameter logic [21:0] MAIN_OFFSET  = 22'h00000,
  parameter logic [21:0] OBJ_OFFSET   = 22'h02000,
  parameter int          REFRESH_IDLE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        loop_rst,
  input  logic        main_cs,
  input  logic [14:0] main_addr,
  output logic [7:0]  main_dout,
  output logic        main_ok,
  input  logic        obj_cs,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_dout,
  output logic        obj_ok,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic [21:0] sdram_addr,
  output logic        refresh_en,
  output logic        ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_MAIN = 1'b0,
    GRANT_OBJ  = 1'b1
  } grant_t;

  localparam logic [7:0] REFRESH_TH = 8'(REFRESH_IDLE);

  state_t      state;
  grant_t      last_grant;
  grant_t      grantee;
  logic [12:0] cap_tag;

  logic        main_valid;
  logic [12:0] main_tag;
  logic [31:0] main_data;
  logic        obj_valid;
  logic [12:0] obj_tag;
  logic [31:0] obj_data;

  logic [7:0]  idle_cnt;

  logic        main_hit;
  logic        main_miss;
  logic        obj_hit;
  logic        obj_miss;
  logic        any_miss;
  logic        grant_obj;
  logic [12:0] grant_tag;
  logic        fill;
  logic        hold;
  logic [7:0]  idle_cnt_next;

  // Cache lookup, grant choice and fill detection.
  // On a tie, OBJ wins only if main was the last client served. A fill can
  // happen in REQ when the controller acks and delivers data in the same
  // cycle.
  always_comb begin
    main_hit      = main_cs & main_valid & (main_tag == main_addr[14:2]);
    main_miss     = main_cs & ~main_hit;
    obj_hit       = obj_cs & obj_valid & (obj_tag == obj_addr);
    obj_miss      = obj_cs & ~obj_hit;
    any_miss      = main_miss | obj_miss;
    grant_obj     = obj_miss & (~main_miss | (last_grant == GRANT_MAIN));
    grant_tag     = grant_obj ? obj_addr : main_addr[14:2];
    fill          = ((state == REQ) & sdram_ack & data_rdy) |
                    ((state == WAIT) & data_rdy);
    hold          = ~rst_n | downloading | loop_rst;
    idle_cnt_next = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;
  end

  // Arbiter state, caches and all registered outputs.
  // A reset and a download/loader hold clear the same registers. Only a real
  // reset restores the turn history, so that main wins the first tie. Because
  // a hold returns the FSM to IDLE, late sdram_ack and data_rdy pulses from
  // an aborted transfer have no effect.
  always_ff @(posedge clk) begin
    if (hold) begin
      state      <= IDLE;
      grantee    <= GRANT_MAIN;
      cap_tag    <= 13'd0;
      main_valid <= 1'b0;
      main_tag   <= 13'd0;
      main_data  <= 32'd0;
      obj_valid  <= 1'b0;
      obj_tag    <= 13'd0;
      obj_data   <= 32'd0;
      idle_cnt   <= 8'd0;
      main_dout  <= 8'd0;
      main_ok    <= 1'b0;
      obj_dout   <= 32'd0;
      obj_ok     <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      refresh_en <= 1'b0;
      ready      <= 1'b0;
      if (!rst_n) begin
        last_grant <= GRANT_OBJ;
      end
    end else begin
      ready     <= 1'b1;
      main_ok   <= main_hit;
      obj_ok    <= obj_hit;
      main_dout <= main_data[{main_addr[1:0], 3'b000} +: 8];
      obj_dout  <= obj_data;

      // The fill goes in under the tag captured at grant time. If the client
      // has moved on since then, the new address simply misses again.
      if (fill) begin
        if (grantee == GRANT_MAIN) begin
          main_valid <= 1'b1;
          main_tag   <= cap_tag;
          main_data  <= data_read;
        end else begin
          obj_valid <= 1'b1;
          obj_tag   <= cap_tag;
          obj_data  <= data_read;
        end
        last_grant <= grantee;
      end

      // Refresh is offered only after a run of idle cycles with no pending
      // miss. Any activity restarts the run.
      if ((state == IDLE) && !any_miss) begin
        idle_cnt   <= idle_cnt_next;
        refresh_en <= (idle_cnt_next >= REFRESH_TH);
      end else begin
        idle_cnt   <= 8'd0;
        refresh_en <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_miss && ready) begin
            grantee    <= grant_obj ? GRANT_OBJ : GRANT_MAIN;
            cap_tag    <= grant_tag;
            sdram_addr <= (grant_obj ? OBJ_OFFSET : MAIN_OFFSET) + {9'd0, grant_tag};
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= data_rdy ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Testbench for jtpopeye_sdram_arb: directed sequences, a hit/miss vector
// table, and randomized traffic against an SDRAM content model.
module tb_jtpopeye_sdram_arb;

  localparam logic [21:0] MAIN_OFFSET = 22'h00000;
  localparam logic [21:0] OBJ_OFFSET  = 22'h02000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic        main_cs = 1'b0;
  logic [14:0] main_addr = 15'd0;
  logic [7:0]  main_dout;
  logic        main_ok;
  logic        obj_cs = 1'b0;
  logic [12:0] obj_addr = 13'd0;
  logic [31:0] obj_dout;
  logic        obj_ok;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = 32'd0;
  logic [21:0] sdram_addr;
  logic        refresh_en;
  logic        ready;

  int tests = 0;
  int fails = 0;

  // Responder state for the randomized phase
  int          r_phase = 0;
  int          r_cnt = 0;
  int          r_dly = 0;
  logic [21:0] r_addr = 22'd0;
  logic        r_fresh = 1'b0;

  typedef struct {
    logic        main_cs;
    logic [14:0] main_addr;
    logic        obj_cs;
    logic [12:0] obj_addr;
    logic        exp_main_ok;
    logic [7:0]  exp_main_dout;
    logic        exp_obj_ok;
    logic [31:0] exp_obj_dout;
  } vec_t;

  vec_t vecs[8];

  jtpopeye_sdram_arb #(
    .MAIN_OFFSET (MAIN_OFFSET),
    .OBJ_OFFSET  (OBJ_OFFSET),
    .REFRESH_IDLE(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .loop_rst   (loop_rst),
    .main_cs    (main_cs),
    .main_addr  (main_addr),
    .main_dout  (main_dout),
    .main_ok    (main_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_dout   (obj_dout),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .sdram_addr (sdram_addr),
    .refresh_en (refresh_en),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Hard stop if the bench ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  // SDRAM contents model: a fixed scramble of the word address
  function automatic logic [31:0] memWord(input logic [21:0] a);
    logic [31:0] x;
    x = {10'd0, a} * 32'h9E3779B1;
    return x ^ 32'hA5C30F96;
  endfunction

  function automatic logic [7:0] mainByte(input logic [14:0] a);
    logic [31:0] w;
    w = memWord(MAIN_OFFSET + {9'd0, a[14:2]});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    main_cs   = v.main_cs;
    main_addr = v.main_addr;
    obj_cs    = v.obj_cs;
    obj_addr  = v.obj_addr;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    main_cs = 1'b0;
    obj_cs = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Ack the pending request, then deliver data one cycle later
  task automatic serveReq(input logic [31:0] data);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    data_read = data;
    tick;
    data_rdy  = 1'b0;
  endtask

  // One cycle of the randomized SDRAM controller: random ack delay, random
  // data delay (zero means data arrives with the ack)
  task automatic respondStep;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    r_fresh   = 1'b0;
    if (r_phase == 0 && sdram_req) begin
      checkOutput("rnd addr range", 32'(sdram_addr[21:14]), 32'd0);
      r_addr  = sdram_addr;
      r_cnt   = int'($urandom_range(0, 3));
      r_dly   = int'($urandom_range(0, 3));
      r_phase = 1;
      r_fresh = 1'b1;
    end
    if (r_phase == 1) begin
      checkOutput("rnd req held", 32'(sdram_req), 32'd1);
      if (!r_fresh) checkOutput("rnd addr stable", 32'(sdram_addr), 32'(r_addr));
      if (r_cnt == 0) begin
        sdram_ack = 1'b1;
        if (r_dly == 0) begin
          data_rdy  = 1'b1;
          data_read = memWord(r_addr);
          r_phase   = 0;
        end else begin
          r_phase = 2;
        end
      end else begin
        r_cnt--;
      end
    end else if (r_phase == 2) begin
      checkOutput("rnd req dropped", 32'(sdram_req), 32'd0);
      r_dly--;
      if (r_dly == 0) begin
        data_rdy  = 1'b1;
        data_read = memWord(r_addr);
        r_phase   = 0;
      end
    end
  endtask

  task automatic checkRandomOutputs;
    if (main_ok) begin
      checkOutput("rnd main_ok needs cs", 32'(main_cs), 32'd1);
      checkOutput("rnd main_dout", 32'(main_dout), 32'(mainByte(main_addr)));
    end
    if (obj_ok) begin
      checkOutput("rnd obj_ok needs cs", 32'(obj_cs), 32'd1);
      checkOutput("rnd obj_dout", obj_dout, memWord(OBJ_OFFSET + {9'd0, obj_addr}));
    end
  endtask

  initial begin
    bit seen_main;
    bit seen_obj;

    vecs[0] = '{1'b1, 15'h0004, 1'b1, 13'h0003, 1'b1, 8'hAA, 1'b1, 32'h11223344};
    vecs[1] = '{1'b1, 15'h0005, 1'b0, 13'h0003, 1'b1, 8'hBB, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 15'h0006, 1'b1, 13'h0003, 1'b1, 8'hCC, 1'b1, 32'h11223344};
    vecs[3] = '{1'b1, 15'h0007, 1'b0, 13'h0000, 1'b1, 8'hDD, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 15'h0007, 1'b1, 13'h0003, 1'b0, 8'h00, 1'b1, 32'h11223344};
    vecs[5] = '{1'b0, 15'h0004, 1'b0, 13'h0003, 1'b0, 8'h00, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 15'h0008, 1'b1, 13'h0002, 1'b0, 8'h00, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 15'h0005, 1'b1, 13'h0003, 1'b1, 8'hBB, 1'b1, 32'h11223344};

    // Reset, then a download that ends
    rst_n = 1'b0;
    downloading = 1'b1;
    tick;
    tick;
    checkOutput("reset main_ok", 32'(main_ok), 32'd0);
    checkOutput("reset obj_ok", 32'(obj_ok), 32'd0);
    checkOutput("reset sdram_req", 32'(sdram_req), 32'd0);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset refresh_en", 32'(refresh_en), 32'd0);
    checkOutput("reset sdram_addr", 32'(sdram_addr), 32'd0);
    rst_n = 1'b1;
    tick;
    tick;
    checkOutput("download ready", 32'(ready), 32'd0);
    downloading = 1'b0;
    tick;
    checkOutput("ready after load", 32'(ready), 32'd1);
    checkOutput("idle sdram_req", 32'(sdram_req), 32'd0);

    // Main byte miss at address 5
    main_cs = 1'b1;
    main_addr = 15'h0005;
    tick;
    checkOutput("main req", 32'(sdram_req), 32'd1);
    checkOutput("main req addr", 32'(sdram_addr), 32'h000001);
    checkOutput("main req refresh_en", 32'(refresh_en), 32'd0);
    tick;
    checkOutput("main req held", 32'(sdram_req), 32'd1);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    checkOutput("main req dropped", 32'(sdram_req), 32'd0);
    data_rdy = 1'b1;
    data_read = 32'hDDCCBBAA;
    tick;
    data_rdy = 1'b0;
    checkOutput("main ok early", 32'(main_ok), 32'd0);
    tick;
    checkOutput("main ok after fill", 32'(main_ok), 32'd1);
    checkOutput("main dout BB", 32'(main_dout), 32'hBB);
    main_addr = 15'h0006;
    tick;
    checkOutput("main dout CC", 32'(main_dout), 32'hCC);
    checkOutput("main ok addr 6", 32'(main_ok), 32'd1);
    checkOutput("no req on hit", 32'(sdram_req), 32'd0);

    // Contention from reset: main first, then obj, then strict alternation
    doReset;
    main_cs = 1'b1;
    main_addr = 15'h0010;
    obj_cs = 1'b1;
    obj_addr = 13'h0003;
    tick;
    checkOutput("tie first addr", 32'(sdram_addr), 32'h000004);
    serveReq(32'h01020304);
    tick;
    checkOutput("tie second req", 32'(sdram_req), 32'd1);
    checkOutput("tie second addr", 32'(sdram_addr), 32'h002003);
    checkOutput("tie main ok", 32'(main_ok), 32'd1);
    serveReq(32'hCAFEF00D);
    tick;
    checkOutput("tie both main ok", 32'(main_ok), 32'd1);
    checkOutput("tie both obj ok", 32'(obj_ok), 32'd1);
    checkOutput("tie main dout", 32'(main_dout), 32'h04);
    checkOutput("tie obj dout", obj_dout, 32'hCAFEF00D);
    main_addr = 15'h0020;
    tick;
    checkOutput("solo main addr", 32'(sdram_addr), 32'h000008);
    serveReq(32'h55555555);
    main_addr = 15'h0030;
    obj_addr = 13'h0005;
    tick;
    checkOutput("alternate obj first", 32'(sdram_addr), 32'h002005);

    // OBJ address changes while the fill is outstanding
    doReset;
    obj_cs = 1'b1;
    obj_addr = 13'h0003;
    tick;
    checkOutput("obj req addr", 32'(sdram_addr), 32'h002003);
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    obj_addr = 13'h0004;
    data_rdy = 1'b1;
    data_read = 32'h12345678;
    tick;
    data_rdy = 1'b0;
    tick;
    checkOutput("stale obj ok", 32'(obj_ok), 32'd0);
    checkOutput("reissue req", 32'(sdram_req), 32'd1);
    checkOutput("reissue addr", 32'(sdram_addr), 32'h002004);

    // Refresh enable after the idle run, dropped by a grant
    doReset;
    obj_cs = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    checkOutput("refresh not yet", 32'(refresh_en), 32'd0);
    tick;
    checkOutput("refresh on", 32'(refresh_en), 32'd1);
    main_cs = 1'b1;
    main_addr = 15'h0000;
    tick;
    checkOutput("refresh off on grant", 32'(refresh_en), 32'd0);
    checkOutput("grant with refresh drop", 32'(sdram_req), 32'd1);

    // Reset while in REQ; late pulses are ignored
    rst_n = 1'b0;
    tick;
    checkOutput("rst drops req", 32'(sdram_req), 32'd0);
    rst_n = 1'b1;
    sdram_ack = 1'b1;
    data_rdy = 1'b1;
    data_read = 32'hFFFFFFFF;
    tick;
    sdram_ack = 1'b0;
    data_rdy = 1'b0;
    tick;
    checkOutput("late data no hit", 32'(main_ok), 32'd0);
    checkOutput("late data new req", 32'(sdram_req), 32'd1);

    // Vector table on prefilled caches
    doReset;
    main_cs = 1'b1;
    main_addr = 15'h0004;
    tick;
    serveReq(32'hDDCCBBAA);
    obj_cs = 1'b1;
    obj_addr = 13'h0003;
    tick;
    serveReq(32'h11223344);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      tick;
      checkOutput($sformatf("vec%0d main_ok", i), 32'(main_ok), 32'(vecs[i].exp_main_ok));
      checkOutput($sformatf("vec%0d obj_ok", i), 32'(obj_ok), 32'(vecs[i].exp_obj_ok));
      if (vecs[i].exp_main_ok)
        checkOutput($sformatf("vec%0d main_dout", i), 32'(main_dout), 32'(vecs[i].exp_main_dout));
      if (vecs[i].exp_obj_ok)
        checkOutput($sformatf("vec%0d obj_dout", i), obj_dout, vecs[i].exp_obj_dout);
    end

    // Loader reset mid-transfer flushes caches
    loop_rst = 1'b1;
    tick;
    checkOutput("loop_rst req", 32'(sdram_req), 32'd0);
    checkOutput("loop_rst ready", 32'(ready), 32'd0);
    checkOutput("loop_rst main_ok", 32'(main_ok), 32'd0);
    loop_rst = 1'b0;
    main_cs = 1'b0;
    obj_cs = 1'b0;
    tick;
    checkOutput("loop_rst ready back", 32'(ready), 32'd1);
    main_cs = 1'b1;
    main_addr = 15'h0004;
    tick;
    checkOutput("flushed main misses", 32'(sdram_req), 32'd1);
    checkOutput("flushed main addr", 32'(sdram_addr), 32'h000001);

    // Randomized traffic against the SDRAM content model
    doReset;
    r_phase = 0;
    for (int i = 0; i < 2500; i++) begin
      tick;
      checkRandomOutputs();
      respondStep();
      if ($urandom_range(0, 3) == 0) main_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) main_addr = 15'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) obj_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) obj_addr = 13'($urandom_range(0, 3));
    end

    // Both clients hold fresh addresses: each must be served
    main_cs = 1'b1;
    main_addr = 15'h7F00;
    obj_cs = 1'b1;
    obj_addr = 13'h1FF0;
    seen_main = 1'b0;
    seen_obj = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      checkRandomOutputs();
      if (main_ok) seen_main = 1'b1;
      if (obj_ok) seen_obj = 1'b1;
      respondStep();
    end
    checkOutput("liveness main", 32'(seen_main), 32'd1);
    checkOutput("liveness obj", 32'(seen_obj), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
